// File: rtl/nn_pkg.sv
// Shared widths, activation limits and controller state encodings for the
// dense-layer output path.
package nn_pkg;

  localparam int ACC_W   = 32;
  localparam int SUM_W   = 33;
  localparam int ACT_W   = 8;
  localparam int ACT_MAX = 127;
  localparam int ACT_MIN = -128;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: optional ReLU, round half toward +inf,
// arithmetic right shift and saturation to a signed activation.
import nn_pkg::*;

module requant_sat #(
  parameter int SHIFT   = 8,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic signed [ACT_W-1:0] q,
  output logic                    sat
);

  // One guard bit so the rounding constant can never wrap the largest sum.
  localparam int EXT_W = SUM_W + 1;
  localparam logic signed [EXT_W-1:0] RND =
    (SHIFT > 0) ? (EXT_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [EXT_W-1:0] HI = EXT_W'(ACT_MAX);
  localparam logic signed [EXT_W-1:0] LO = EXT_W'(ACT_MIN);

  logic signed [EXT_W-1:0] relu_v;
  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    relu_v = EXT_W'(sum);
    if (RELU_EN && sum[SUM_W-1]) relu_v = '0;
    shifted = (relu_v + RND) >>> SHIFT;
    q   = '0;
    sat = 1'b0;
    if (shifted > HI) begin
      q   = ACT_W'(ACT_MAX);
      sat = 1'b1;
    end else if (shifted < LO) begin
      q   = ACT_W'(ACT_MIN);
      sat = 1'b1;
    end else begin
      q = shifted[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/dense_requant_argmax.sv
// Dense-layer output stage: bias add, requantize to int8 and per-frame argmax.
//   state  | meaning
//   S_RUN  | accepting results, tracking best score of the frame
//   S_EMIT | one cycle: publish winning class index and score
import nn_pkg::*;

module dense_requant_argmax #(
  parameter int NUM_NEURONS = 10,
  parameter int IDX_W       = 4,
  parameter int SHIFT       = 8,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic                    acc_valid,
  input  logic signed [ACC_W-1:0] bias_in,
  output logic signed [ACT_W-1:0] q_out,
  output logic                    q_valid,
  output logic [IDX_W-1:0]        q_index,
  output logic                    q_sat,
  output logic [IDX_W-1:0]        class_id,
  output logic signed [SUM_W-1:0] class_score,
  output logic                    class_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  logic [IDX_W-1:0]        cnt;
  logic [IDX_W-1:0]        cur_idx;
  logic                    s1_valid;
  logic                    s1_last;
  logic [IDX_W-1:0]        s1_idx;
  logic signed [SUM_W-1:0] s1_sum;
  logic signed [SUM_W-1:0] best_sum;
  logic [IDX_W-1:0]        best_idx;
  logic signed [ACT_W-1:0] rq;
  logic                    rq_sat;
  logic                    emit;
  state_t                  state, state_nxt;

  // A sample arriving with frame_start is already index 0 of the new frame.
  assign cur_idx = frame_start ? '0 : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (acc_valid) begin
      cnt <= (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
    end else if (frame_start) begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= acc_valid;
      if (acc_valid) begin
        s1_sum  <= SUM_W'(acc_in) + SUM_W'(bias_in);
        s1_idx  <= cur_idx;
        s1_last <= (cur_idx == LAST_IDX);
      end
    end
  end

  requant_sat #(
    .SHIFT  (SHIFT),
    .RELU_EN(RELU_EN)
  ) u_requant_sat (
    .sum(s1_sum),
    .q  (rq),
    .sat(rq_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_out   <= '0;
      q_sat   <= 1'b0;
      q_index <= '0;
    end else begin
      q_valid <= s1_valid;
      if (s1_valid) begin
        q_out   <= rq;
        q_sat   <= rq_sat;
        q_index <= s1_idx;
      end
    end
  end

  // Argmax runs on the pre-ReLU sum; frame_start drops whatever is in stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_sum <= '0;
      best_idx <= '0;
    end else if (frame_start) begin
      best_sum <= '0;
      best_idx <= '0;
    end else if (s1_valid && (s1_idx == '0 || s1_sum > best_sum)) begin
      best_sum <= s1_sum;
      best_idx <= s1_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    case (state)
      S_RUN: begin
        if (s1_valid && s1_last && !frame_start) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        emit      = !frame_start;
        state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_valid <= 1'b0;
      class_id    <= '0;
      class_score <= '0;
    end else begin
      class_valid <= emit;
      if (emit) begin
        class_id    <= best_idx;
        class_score <= best_sum;
      end
    end
  end

endmodule

// File: doc/dense_requant_argmax.md
Name: dense_requant_argmax

Overview:
- Sits directly downstream of the pipelined int8 dot-product MAC, one instance per output layer.
- Takes each 32-bit dot-product result and its 32-bit bias, then adds, applies optional ReLU, rounds, shifts and saturates to int8 for the next layer.
- Also tracks the argmax over NUM_NEURONS results per frame and emits the winning class index for the MNIST classifier.

Parameters:
- NUM_NEURONS, 10: results per frame. Legal range is at least 2.
- IDX_W, 4: index width. Must satisfy 2^IDX_W >= NUM_NEURONS.
- SHIFT, 8: requantization right-shift. Legal range 0..24.
- RELU_EN, 1: 1 clamps negative sums to 0 before quantizing.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- frame_start  in  1  synchronous pulse: clears neuron index and argmax state
- acc_in  in  32  signed dot-product result
- acc_valid  in  1  acc_in and bias_in are valid this cycle
- bias_in  in  32  signed bias aligned with acc_in
- q_out  out  8  signed requantized activation
- q_valid  out  1  q_out valid (one-cycle pulse)
- q_index  out  IDX_W  neuron index of q_out
- q_sat  out  1  q_out was saturated (qualified by q_valid)
- class_id  out  IDX_W  argmax index
- class_score  out  33  signed winning pre-quant sum
- class_valid  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, rst=1): all outputs, the neuron counter and the best score/index go to 0; state goes to S_RUN.
- Stage 1, on acc_valid:
  - sum = sign-extended acc_in + sign-extended bias_in, carried at 33 bits (cannot overflow).
  - Register sum, the current index and the last flag (index == NUM_NEURONS-1).
- Stage 2:
  - ReLU: if RELU_EN and sum < 0, use 0.
  - Rounding: if SHIFT > 0, add 2^(SHIFT-1), then arithmetic-shift right by SHIFT (round half toward +inf).
  - Saturation: saturate to [-128, 127]; q_sat = 1 when clamping occurred.
  - Timing: q_valid asserts exactly 2 cycles after the acc_valid that produced it. Back-to-back acc_valid is fully pipelined, throughput 1 per cycle.
- Argmax (updated in stage 2 on the un-quantized, pre-ReLU sum):
  - Index 0 of a frame loads best unconditionally.
  - Later indices replace best only when sum > best (strictly greater), so ties keep the lowest index.
- Neuron counter:
  - Increments on each acc_valid.
  - Wraps to 0 after NUM_NEURONS-1.
- State machine, two states:
  - S_RUN: on stage 2 completing the last-index result, go to S_EMIT.
  - S_EMIT (one cycle): class_valid=1, with class_id/class_score driven from best (including the last result); return to S_RUN.
  - class_valid therefore rises 3 cycles after the last acc_valid.
  - class_id and class_score hold their values until the next class_valid or reset.
- acc_valid during S_EMIT is accepted normally as index 0 of the next frame; no stall and no backpressure.
- frame_start:
  - Clears the counter and flushes in-flight argmax tracking; a pending class_valid is cancelled.
  - If frame_start and acc_valid occur in the same cycle, that sample is index 0 of the new frame.
  - Pipeline q_valid outputs already in flight still emit.
- Reset mid-frame aborts everything immediately; no q_valid or class_valid follows.

Decomposition:
- Shared package (nn_pkg): ACC_W=32, SUM_W=33, ACT_W=8, ACT_MAX=127, ACT_MIN=-128, state encodings S_RUN/S_EMIT.
- Sub-module requant_sat: combinational ReLU, round, shift and saturate from SUM_W to ACT_W, with a sat flag.
  - Parameterized by SHIFT and RELU_EN.
  - Reused later by the conv-layer output path.

Test Plan:
1. SHIFT=8, RELU_EN=0: acc_in=1000, bias_in=28 -> 2 cycles later q_out=4, q_sat=0, q_index=0.
2. RELU_EN=0: acc_in=-1000, bias_in=0 -> q_out=-4. With RELU_EN=1 the same input -> q_out=0, q_sat=0.
3. Saturation: acc_in=100000, bias_in=0 -> q_out=127, q_sat=1. acc_in=-100000, RELU_EN=0 -> q_out=-128, q_sat=1.
4. Frame of 10 back-to-back sums {5,9,9,2,-7,0,3,9,1,4} (bias 0) -> ten q_valid pulses on consecutive cycles, then class_valid 3 cycles after the last input with class_id=1, class_score=9. Immediately follow with a second frame with max at index 9 -> class_id=9.
5. Wide sum: acc_in=32'h7FFFFFFF, bias_in=1 at index 3, others 0 -> class_score=2^31 (no wrap), class_id=3, q_out=127, q_sat=1.
6. Boundaries:
   - frame_start after 4 samples -> next sample is q_index=0, and class_valid comes only after 10 further samples.
   - rst asserted mid-frame -> outputs 0 immediately, no class_valid.
